// File: rtl/multiword_add_seq.sv
// multiword_add_seq: feeds operand limbs (LS first) through one ripple_carry_adder, chaining carry across limbs.
// Latency: 1 cycle from accepted limb to out_valid; 1 limb/cycle sustained while out_ready=1.
// Backpressure: in_ready = !out_valid || out_ready; held result fields are stable while stalled.
// Optional feature: define MULTIWORD_SUB_EN to add the in_sub port (multi-limb A - B).

module ripple_carry_adder #(
   parameter int NUMBITS = 16
) (
   input  logic [NUMBITS-1:0] A,
   input  logic [NUMBITS-1:0] B,
   input  logic               carryin,
   output logic [NUMBITS-1:0] result,
   output logic               carryout
);
   logic [NUMBITS:0] c;

   assign c[0] = carryin;

   // One full adder per bit, carry rippling upward.
   genvar i;
   generate
      for (i = 0; i < NUMBITS; i++) begin : g_fa
         assign result[i] = A[i] ^ B[i] ^ c[i];
         assign c[i+1]    = (A[i] & B[i]) | (A[i] & c[i]) | (B[i] & c[i]);
      end
   endgenerate

   assign carryout = c[NUMBITS];
endmodule

module multiword_add_seq #(
   parameter int NUMBITS = 16,
   parameter int IDXBITS = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [NUMBITS-1:0] in_a,
   input  logic [NUMBITS-1:0] in_b,
   input  logic               in_last,
`ifdef MULTIWORD_SUB_EN
   input  logic               in_sub,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NUMBITS-1:0] out_sum,
   output logic               out_last,
   output logic [IDXBITS-1:0] out_index,
   output logic               out_carry,
   output logic               out_overflow,
   output logic               busy
);
   typedef enum logic {IDLE = 1'b0, MID = 1'b1} state_t;

   state_t               state_q, state_d;
   logic                 carry_q;
   logic [IDXBITS-1:0]   idx_q;
   logic                 accept;
   logic                 sub_eff;
   logic [NUMBITS-1:0]   b_eff;
   logic                 cin;
   logic [NUMBITS-1:0]   add_sum;
   logic                 add_cout;
   logic                 ovf;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign busy     = (state_q == MID);

`ifdef MULTIWORD_SUB_EN
   logic sub_q;

   // Operation mode is taken from the first limb only and held until the last.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sub_q <= 1'b0;
      else if (accept && state_q == IDLE)
         sub_q <= in_sub;
   end

   assign sub_eff = (state_q == IDLE) ? in_sub : sub_q;
`else
   assign sub_eff = 1'b0;
`endif

   // Subtraction is A + ~B + 1, the +1 injected as the first-limb carry-in.
   assign b_eff = sub_eff ? ~in_b : in_b;
   assign cin   = (state_q == IDLE) ? sub_eff : carry_q;

   ripple_carry_adder #(.NUMBITS(NUMBITS)) u_adder (
      .A        (in_a),
      .B        (b_eff),
      .carryin  (cin),
      .result   (add_sum),
      .carryout (add_cout)
   );

   // Signed overflow only has meaning on the most significant limb.
   assign ovf = in_last
              && (in_a[NUMBITS-1] == b_eff[NUMBITS-1])
              && (add_sum[NUMBITS-1] != in_a[NUMBITS-1]);

   // Next-state: IDLE marks "next limb starts an operation".
   always_comb begin
      state_d = state_q;
      if (accept) begin
         case (state_q)
            IDLE:    state_d = in_last ? IDLE : MID;
            MID:     state_d = in_last ? IDLE : MID;
            default: state_d = IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Inter-limb carry and limb index; index saturates rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry_q <= 1'b0;
         idx_q   <= '0;
      end else if (accept) begin
         carry_q <= add_cout;
         if (in_last)
            idx_q <= '0;
         else if (idx_q != {IDXBITS{1'b1}})
            idx_q <= idx_q + 1'b1;
      end
   end

   // Single-entry output stage: loads on accept, drains when downstream takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_sum      <= '0;
         out_last     <= 1'b0;
         out_index    <= '0;
         out_carry    <= 1'b0;
         out_overflow <= 1'b0;
      end else if (accept) begin
         out_valid    <= 1'b1;
         out_sum      <= add_sum;
         out_last     <= in_last;
         out_index    <= idx_q;
         out_carry    <= add_cout;
         out_overflow <= ovf;
      end else if (out_ready) begin
         out_valid    <= 1'b0;
      end
   end
endmodule

// File: tb/tb_multiword_add_seq.sv
module tb_multiword_add_seq;
   localparam int NUMBITS = 16;
   localparam int IDXBITS = 8;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic [NUMBITS-1:0] in_a;
   logic [NUMBITS-1:0] in_b;
   logic               in_last;
`ifdef MULTIWORD_SUB_EN
   logic               in_sub;
`endif
   logic               out_valid;
   logic               out_ready;
   logic [NUMBITS-1:0] out_sum;
   logic               out_last;
   logic [IDXBITS-1:0] out_index;
   logic               out_carry;
   logic               out_overflow;
   logic               busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   multiword_add_seq #(.NUMBITS(NUMBITS), .IDXBITS(IDXBITS)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_a         (in_a),
      .in_b         (in_b),
      .in_last      (in_last),
`ifdef MULTIWORD_SUB_EN
      .in_sub       (in_sub),
`endif
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_sum      (out_sum),
      .out_last     (out_last),
      .out_index    (out_index),
      .out_carry    (out_carry),
      .out_overflow (out_overflow),
      .busy         (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present a limb (or idle), then wait one rising edge plus 1 time unit.
   task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b, input logic last);
      in_valid = v;
      in_a     = a;
      in_b     = b;
      in_last  = last;
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [15:0] sum, input logic carry,
                            input int idx, input logic last, input logic ovf, input logic bsy);
      check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, ".sum"},   {16'd0, out_sum}, {16'd0, sum});
      check({tag, ".carry"}, {31'd0, out_carry}, {31'd0, carry});
      check({tag, ".index"}, {24'd0, out_index}, idx);
      check({tag, ".last"},  {31'd0, out_last}, {31'd0, last});
      check({tag, ".ovf"},   {31'd0, out_overflow}, {31'd0, ovf});
      check({tag, ".busy"},  {31'd0, busy}, {31'd0, bsy});
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
`ifdef MULTIWORD_SUB_EN
      in_sub    = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      // Reset state
      check("rst.valid", {31'd0, out_valid}, 32'd0);
      check("rst.sum",   {16'd0, out_sum}, 32'd0);
      check("rst.index", {24'd0, out_index}, 32'd0);
      check("rst.busy",  {31'd0, busy}, 32'd0);
      check("rst.ready", {31'd0, in_ready}, 32'd1);
      check("rst.ovf",   {31'd0, out_overflow}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single limb 1 + 2
      step(1'b1, 16'h0001, 16'h0002, 1'b1);
      check_out("single", 16'h0003, 1'b0, 0, 1'b1, 1'b0, 1'b0);

      // Two-limb carry chain, back-to-back after the previous operation
      step(1'b1, 16'hFFFF, 16'h0001, 1'b0);
      check_out("chain0", 16'h0000, 1'b1, 0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 16'h0000, 16'h0000, 1'b1);
      check_out("chain1", 16'h0001, 1'b0, 1, 1'b1, 1'b0, 1'b0);

      // Signed overflow on a single last limb
      step(1'b1, 16'h7FFF, 16'h0001, 1'b1);
      check_out("ovf", 16'h8000, 1'b0, 0, 1'b1, 1'b1, 1'b0);

      // Same bit pattern on a non-last limb must not flag overflow
      step(1'b1, 16'h7FFF, 16'h0001, 1'b0);
      check_out("noovf0", 16'h8000, 1'b0, 0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 16'h0000, 16'h0000, 1'b1);
      check_out("noovf1", 16'h0000, 1'b0, 1, 1'b1, 1'b0, 1'b0);

      // Drain
      step(1'b0, 16'h0000, 16'h0000, 1'b0);
      check("drain.valid", {31'd0, out_valid}, 32'd0);

      // Backpressure: hold out_ready low with a pending limb
      out_ready = 1'b0;
      step(1'b1, 16'h0005, 16'h0006, 1'b0);
      check_out("bp0", 16'h000B, 1'b0, 0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 16'h0010, 16'h0020, 1'b1);
         check("bp.ready", {31'd0, in_ready}, 32'd0);
         check("bp.sum",   {16'd0, out_sum}, 32'h000B);
         check("bp.index", {24'd0, out_index}, 32'd0);
         check("bp.valid", {31'd0, out_valid}, 32'd1);
         check("bp.busy",  {31'd0, busy}, 32'd1);
      end
      out_ready = 1'b1;
      #1;
      check("bp.release_ready", {31'd0, in_ready}, 32'd1);
      step(1'b1, 16'h0010, 16'h0020, 1'b1);
      check_out("bp1", 16'h0030, 1'b0, 1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 16'h0000, 1'b0);
      check("bp.drained", {31'd0, out_valid}, 32'd0);

      // Index saturation: 257 non-last limbs, then a last limb
      for (int k = 0; k < 257; k++) begin
         step(1'b1, 16'h0000, 16'h0000, 1'b0);
         if (k == 254) check("sat.254", {24'd0, out_index}, 32'd254);
         if (k == 255) check("sat.255", {24'd0, out_index}, 32'd255);
      end
      check("sat.256", {24'd0, out_index}, 32'd255);
      step(1'b1, 16'h0000, 16'h0000, 1'b1);
      check_out("sat.last", 16'h0000, 1'b0, 255, 1'b1, 1'b0, 1'b0);
      step(1'b1, 16'h0004, 16'h0004, 1'b1);
      check_out("sat.next", 16'h0008, 1'b0, 0, 1'b1, 1'b0, 1'b0);

      // Reset mid-operation discards carry and held output
      step(1'b1, 16'hFFFF, 16'h0001, 1'b0);
      check_out("mrst0", 16'h0000, 1'b1, 0, 1'b0, 1'b0, 1'b1);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("mrst.valid", {31'd0, out_valid}, 32'd0);
      check("mrst.sum",   {16'd0, out_sum}, 32'd0);
      check("mrst.carry", {31'd0, out_carry}, 32'd0);
      check("mrst.busy",  {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b1, 16'h0001, 16'h0001, 1'b1);
      check_out("mrst1", 16'h0002, 1'b0, 0, 1'b1, 1'b0, 1'b0);

`ifdef MULTIWORD_SUB_EN
      // Subtract: 0x0001_0000 - 0x0000_0001
      in_sub = 1'b1;
      step(1'b1, 16'h0000, 16'h0001, 1'b0);
      check_out("sub0", 16'hFFFF, 1'b0, 0, 1'b0, 1'b0, 1'b1);
      in_sub = 1'b0;
      step(1'b1, 16'h0001, 16'h0000, 1'b1);
      check_out("sub1", 16'h0000, 1'b1, 1, 1'b1, 1'b0, 1'b0);
`endif

      step(1'b0, 16'h0000, 16'h0000, 1'b0);
      check("end.valid", {31'd0, out_valid}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
